// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_operand_sequencer.
// Holds the FSM state encoding, the operand/carry/result widths and the
// bit positions inside the flags byte. The S_CHK state exists only when
// ALU_SEQ_CHK_EN is defined.
package alu_seq_pkg;

  localparam int unsigned OPW   = 8;            // operand / stream byte width
  localparam int unsigned COUTW = 3;            // ALU carry-out width
  localparam int unsigned RESW  = OPW + COUTW;  // registered result width (11)

  // Flags byte layout: bit 0 is carry-in, bits 7:1 are reserved (must be 0)
  localparam int unsigned FLAG_CIN_BIT  = 0;
  localparam int unsigned FLAG_RSVD_LSB = 1;
  localparam int unsigned FLAG_RSVD_MSB = 7;

  typedef enum logic [2:0] {
    S_A,
    S_B,
    S_F,
    S_EXEC,
    S_HI,
    S_LO
`ifdef ALU_SEQ_CHK_EN
    , S_CHK
`endif
  } state_t;

endpackage

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
// Collects an operand byte A, an operand byte B and a flags byte from an
// inbound valid/ready stream, presents them as registered operands to an
// external combinational ALU, waits EXEC_WAIT cycles, captures the 11-bit
// result and emits it as two bytes (high then low) on an outbound
// valid/ready stream.
//
// Optional feature (macro ALU_SEQ_CHK_EN): a third output byte carrying
// hi ^ lo ^ A ^ B ^ flags.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_valid/in_ready    inbound byte stream (A, B, flags)
//   abort                 synchronous transaction cancel
//   alu_a/alu_b/alu_cin   registered ALU operands
//   alu_sum/alu_cout      combinational ALU result
//   out_data/out_valid/out_ready outbound result bytes
//   busy                  high in every state but S_A
//   flag_err              sticky: a flags byte had reserved bits set
//   txn_count             completed transactions (wraps)
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned EXEC_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPW-1:0]   in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic [OPW-1:0]   alu_a,
  output logic [OPW-1:0]   alu_b,
  output logic             alu_cin,
  input  logic [OPW-1:0]   alu_sum,
  input  logic [COUTW-1:0] alu_cout,
  output logic [OPW-1:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             flag_err,
  output logic [7:0]       txn_count
);

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [OPW-1:0]  alu_a_q;
  logic [OPW-1:0]  alu_b_q;
  logic            alu_cin_q;
  logic [RESW-1:0] res_q;
  logic [OPW-1:0]  out_data_q;
  logic            out_valid_q;
  logic            flag_err_q;
  logic [7:0]      txn_q;
`ifdef ALU_SEQ_CHK_EN
  logic [OPW-1:0]  chk_q;
`endif

  logic            accept;

  // in_ready is gated by rst_n so it reads low while reset is held
  assign in_ready  = rst_n && (state_q == S_A || state_q == S_B || state_q == S_F);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != S_A);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cin   = alu_cin_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign flag_err  = flag_err_q;
  assign txn_count = txn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_A;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cin_q   <= 1'b0;
      res_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      flag_err_q  <= 1'b0;
      txn_q       <= '0;
`ifdef ALU_SEQ_CHK_EN
      chk_q       <= '0;
`endif
    end else if (abort) begin
      // Abort beats any same-cycle transfer; operands and status are kept
      state_q     <= S_A;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_A: if (accept) begin
          alu_a_q <= in_data;
`ifdef ALU_SEQ_CHK_EN
          chk_q   <= in_data;
`endif
          state_q <= S_B;
        end
        S_B: if (accept) begin
          alu_b_q <= in_data;
`ifdef ALU_SEQ_CHK_EN
          chk_q   <= chk_q ^ in_data;
`endif
          state_q <= S_F;
        end
        S_F: if (accept) begin
          alu_cin_q <= in_data[FLAG_CIN_BIT];
          if (|in_data[FLAG_RSVD_MSB:FLAG_RSVD_LSB]) flag_err_q <= 1'b1;
`ifdef ALU_SEQ_CHK_EN
          chk_q     <= chk_q ^ in_data;
`endif
          cnt_q     <= 4'(EXEC_WAIT - 1);
          state_q   <= S_EXEC;
        end
        S_EXEC: begin
          if (cnt_q == '0) begin
            res_q       <= {alu_cout, alu_sum};
            out_data_q  <= {{(OPW-COUTW){1'b0}}, alu_cout};
            out_valid_q <= 1'b1;
            state_q     <= S_HI;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_HI: if (out_ready) begin
          out_data_q <= res_q[OPW-1:0];
          state_q    <= S_LO;
        end
        S_LO: if (out_ready) begin
`ifdef ALU_SEQ_CHK_EN
          out_data_q <= chk_q ^ res_q[OPW-1:0] ^ {{(OPW-COUTW){1'b0}}, res_q[RESW-1:OPW]};
          state_q    <= S_CHK;
`else
          out_valid_q <= 1'b0;
          txn_q       <= txn_q + 8'd1;
          state_q     <= S_A;
`endif
        end
`ifdef ALU_SEQ_CHK_EN
        S_CHK: if (out_ready) begin
          out_valid_q <= 1'b0;
          txn_q       <= txn_q + 8'd1;
          state_q     <= S_A;
        end
`endif
        default: state_q <= S_A;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer with a behavioural ALU as
// its downstream neighbour (sum of operands plus carry, or a forced value).
// Honours ALU_SEQ_CHK_EN for the optional checksum byte.
module tb_alu_operand_sequencer;

  localparam int unsigned EW = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        abort = 1'b0;
  logic [7:0]  alu_a, alu_b;
  logic        alu_cin;
  logic [7:0]  alu_sum;
  logic [2:0]  alu_cout;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy, flag_err;
  logic [7:0]  txn_count;

  logic        ov_en = 1'b0;
  logic [10:0] ov_val = '0;
  logic [10:0] alu_res;

  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  int          nvec = 0;
  int          nerr = 0;
  logic [7:0]  exp_txn = '0;

  always #5 clk = ~clk;

  assign alu_res  = ov_en ? ov_val : (11'(alu_a) + 11'(alu_b) + 11'(alu_cin));
  assign alu_sum  = alu_res[7:0];
  assign alu_cout = alu_res[10:8];

  alu_operand_sequencer #(.EXEC_WAIT(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .abort(abort),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_sum(alu_sum), .alu_cout(alu_cout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .flag_err(flag_err), .txn_count(txn_count)
  );

  // Capture every completed output transfer
  always @(posedge clk)
    if (rst_n && out_valid && out_ready && !abort) obs_q.push_back(out_data);

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      nvec++; nerr++;
      $display("FAIL in_ready_wait: got in_ready=0, expected 1 within 100 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
    logic [10:0] r;
    logic [7:0]  hi, lo;
    r  = ov_en ? ov_val : (11'(a) + 11'(b) + 11'(f[0]));
    hi = {5'b0, r[10:8]};
    lo = r[7:0];
    exp_q.push_back(hi);
    exp_q.push_back(lo);
`ifdef ALU_SEQ_CHK_EN
    exp_q.push_back(hi ^ lo ^ a ^ b ^ f);
`endif
    send_byte(a);
    send_byte(b);
    send_byte(f);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    nvec++; if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      nerr++; $display("FAIL reset_ctrl: got rdy=%b busy=%b ov=%b, expected 0 0 0", in_ready, busy, out_valid); end
    nvec++; if (alu_a !== 8'h0 || alu_b !== 8'h0 || alu_cin !== 1'b0 || out_data !== 8'h0) begin
      nerr++; $display("FAIL reset_data: got a=%h b=%h cin=%b od=%h, expected zeros", alu_a, alu_b, alu_cin, out_data); end
    nvec++; if (flag_err !== 1'b0 || txn_count !== 8'h0) begin
      nerr++; $display("FAIL reset_status: got ferr=%b txn=%0d, expected 0 0", flag_err, txn_count); end
    rst_n = 1'b1;
    @(negedge clk);
    nvec++; if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL idle_ready: got %b, expected 1", in_ready); end
  endtask

  task automatic test_basic();
    int n, lat;
    logic [7:0] e, o;
    out_ready = 1'b1;
    send_txn(8'd10, 8'd5, 8'h01);
    lat = 1;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    nvec++; if (lat != EW + 1) begin
      nerr++; $display("FAIL latency: got %0d, expected %0d", lat, EW + 1); end
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 300) begin @(negedge clk); n++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nvec++;
      if (obs_q.size() == 0) begin nerr++; $display("FAIL basic_byte: got none, expected %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin nerr++; $display("FAIL basic_byte: got %h, expected %h", o, e); end end
    end
    exp_txn++;
    nvec++; if (alu_a !== 8'd10 || alu_b !== 8'd5 || alu_cin !== 1'b1) begin
      nerr++; $display("FAIL basic_ops: got a=%0d b=%0d cin=%b, expected 10 5 1", alu_a, alu_b, alu_cin); end
    nvec++; if (txn_count !== exp_txn) begin
      nerr++; $display("FAIL basic_txn: got %0d, expected %0d", txn_count, exp_txn); end
  endtask

  task automatic test_wide_result();
    int n;
    logic [7:0] e, o;
    ov_en = 1'b1; ov_val = 11'd1530;
    send_txn(8'd255, 8'd255, 8'h00);
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 300) begin @(negedge clk); n++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nvec++;
      if (obs_q.size() == 0) begin nerr++; $display("FAIL wide_byte: got none, expected %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin nerr++; $display("FAIL wide_byte: got %h, expected %h", o, e); end end
    end
    exp_txn++;
    ov_en = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    logic [7:0] e, o;
    out_ready = 1'b0;
    send_txn(8'd200, 8'd100, 8'h01);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      nvec++; if (out_valid !== 1'b1 || out_data !== exp_q[0] || in_ready !== 1'b0) begin
        nerr++; $display("FAIL hold_hi: got ov=%b od=%h rdy=%b, expected 1 %h 0", out_valid, out_data, exp_q[0], in_ready); end
    end
    out_ready = 1'b1;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 300) begin @(negedge clk); n++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nvec++;
      if (obs_q.size() == 0) begin nerr++; $display("FAIL bp_byte: got none, expected %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin nerr++; $display("FAIL bp_byte: got %h, expected %h", o, e); end end
    end
    exp_txn++;
  endtask

  task automatic test_abort();
    int n;
    logic [7:0] e, o;
    out_ready = 1'b1;
    send_byte(8'd7);
    send_byte(8'd8);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    nvec++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL abort_idle: got busy=%b rdy=%b, expected 0 1", busy, in_ready); end
    send_txn(8'd3, 8'd4, 8'h00);
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 300) begin @(negedge clk); n++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nvec++;
      if (obs_q.size() == 0) begin nerr++; $display("FAIL abort_fresh: got none, expected %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin nerr++; $display("FAIL abort_fresh: got %h, expected %h", o, e); end end
    end
    exp_txn++;
    nvec++; if (alu_a !== 8'd3 || alu_b !== 8'd4 || txn_count !== exp_txn) begin
      nerr++; $display("FAIL abort_after: got a=%0d b=%0d txn=%0d, expected 3 4 %0d", alu_a, alu_b, txn_count, exp_txn); end
    // Abort colliding with the final-byte transfer
    out_ready = 1'b0;
    send_txn(8'd1, 8'd2, 8'h00);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    nvec++; if (out_valid !== 1'b0 || txn_count !== exp_txn) begin
      nerr++; $display("FAIL abort_xfer: got ov=%b txn=%0d, expected 0 %0d", out_valid, txn_count, exp_txn); end
    e = exp_q.pop_front(); nvec++;
    if (obs_q.size() != 1) begin nerr++; $display("FAIL abort_obs: got %0d bytes, expected 1", obs_q.size()); end
    else begin o = obs_q.pop_front(); if (o !== e) begin nerr++; $display("FAIL abort_hi: got %h, expected %h", o, e); end end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_flags_wrap();
    int n;
    logic [7:0] e, o, f;
    out_ready = 1'b1;
    send_txn(8'h11, 8'h22, 8'h83);
    nvec++; if (alu_cin !== 1'b1 || flag_err !== 1'b1) begin
      nerr++; $display("FAIL flags_err: got cin=%b ferr=%b, expected 1 1", alu_cin, flag_err); end
    do begin
      n = 0;
      while (obs_q.size() < exp_q.size() && n < 300) begin @(negedge clk); n++; end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); nvec++;
        if (obs_q.size() == 0) begin nerr++; $display("FAIL wrap_byte: got none, expected %h", e); end
        else begin o = obs_q.pop_front(); if (o !== e) begin nerr++; $display("FAIL wrap_byte: got %h, expected %h", o, e); end end
      end
      exp_txn++;
      if (exp_txn != 8'd0) begin
        f = 8'($urandom_range(0, 1));
        send_txn(8'($urandom), 8'($urandom), f);
      end
    end while (exp_txn != 8'd0);
    nvec++; if (txn_count !== 8'd0 || flag_err !== 1'b1) begin
      nerr++; $display("FAIL wrap_txn: got txn=%0d ferr=%b, expected 0 1", txn_count, flag_err); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [7:0] e, o;
    send_byte(8'h55);
    send_byte(8'h66);
    rst_n = 1'b0;
    @(negedge clk);
    nvec++; if (busy !== 1'b0 || alu_a !== 8'h0 || flag_err !== 1'b0 || txn_count !== 8'h0) begin
      nerr++; $display("FAIL midreset: got busy=%b a=%h ferr=%b txn=%0d, expected 0 00 0 0", busy, alu_a, flag_err, txn_count); end
    rst_n = 1'b1;
    exp_txn = '0;
    @(negedge clk);
    send_txn(8'd9, 8'd9, 8'h00);
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 300) begin @(negedge clk); n++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nvec++;
      if (obs_q.size() == 0) begin nerr++; $display("FAIL rst_byte: got none, expected %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin nerr++; $display("FAIL rst_byte: got %h, expected %h", o, e); end end
    end
    exp_txn++;
    nvec++; if (alu_a !== 8'd9 || txn_count !== exp_txn) begin
      nerr++; $display("FAIL rst_after: got a=%0d txn=%0d, expected 9 %0d", alu_a, txn_count, exp_txn); end
  endtask

`ifdef ALU_SEQ_CHK_EN
  task automatic test_checksum();
    int n;
    logic [7:0] e, o;
    ov_en = 1'b1; ov_val = 11'd1;
    send_txn(8'd0, 8'd0, 8'h01);
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 300) begin @(negedge clk); n++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nvec++;
      if (obs_q.size() == 0) begin nerr++; $display("FAIL chk_byte: got none, expected %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin nerr++; $display("FAIL chk_byte: got %h, expected %h", o, e); end end
    end
    exp_txn++;
    ov_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wide_result();
    test_backpressure();
    test_abort();
    test_flags_wrap();
    test_reset_mid();
`ifdef ALU_SEQ_CHK_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
